// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator for a word-only single-port memory.
// Adds RV32I byte/halfword loads with extension and read-modify-write sub-word stores.
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_read_en_o,
    output logic        mem_write_en_o,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_WR   = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        ready_q, ready_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        accept;
    logic        req_err;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_ext;
    logic [31:0] merge_word;

    assign accept = req_valid_i && ready_q;

    always_comb begin
        req_err = 1'b0;
        if (req_we_i) begin
            if (req_funct3_i[2] || (req_funct3_i[1:0] == 2'b11)) begin
                req_err = 1'b1;
            end
        end else begin
            if ((req_funct3_i == 3'b011) || (req_funct3_i == 3'b110) ||
                (req_funct3_i == 3'b111)) begin
                req_err = 1'b1;
            end
        end
        if ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) begin
            req_err = 1'b1;
        end
        if ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00)) begin
            req_err = 1'b1;
        end
    end

    always_comb begin
        case (addr_q[1:0])
            2'd0:    byte_lane = mem_rdata_i[7:0];
            2'd1:    byte_lane = mem_rdata_i[15:8];
            2'd2:    byte_lane = mem_rdata_i[23:16];
            default: byte_lane = mem_rdata_i[31:24];
        endcase
        half_lane = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{byte_lane[7]}}, byte_lane};
            3'b001:  load_ext = {{16{half_lane[15]}}, half_lane};
            3'b010:  load_ext = mem_rdata_i;
            3'b100:  load_ext = {24'd0, byte_lane};
            3'b101:  load_ext = {16'd0, half_lane};
            default: load_ext = 32'd0;
        endcase
    end

    // Per byte lane: take store data if the lane is addressed, else keep the memory byte.
    // funct3_q[0] distinguishes SH (half lanes) from SB (byte lanes).
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
        localparam logic [1:0] LANE = 2'(gi);
        logic       lane_sel;
        logic [7:0] store_byte;
        assign lane_sel   = funct3_q[0] ? (addr_q[1] == LANE[1]) : (addr_q[1:0] == LANE);
        assign store_byte = (funct3_q[0] && LANE[0]) ? data_q[15:8] : data_q[7:0];
        assign merge_word[8*gi +: 8] = lane_sel ? store_byte : mem_rdata_i[8*gi +: 8];
    end

    always_comb begin
        state_d        = state_q;
        we_d           = we_q;
        funct3_d       = funct3_q;
        addr_d         = addr_q;
        data_d         = data_q;
        rdata_d        = rdata_q;
        err_d          = err_q;
        req_ready_o    = ready_q;
        resp_valid_o   = (state_q == S_RESP);
        resp_rdata_o   = rdata_q;
        resp_err_o     = err_q;
        mem_read_en_o  = (state_q == S_RD);
        mem_write_en_o = (state_q == S_WR);
        mem_addr_o     = 32'd0;
        mem_wdata_o    = 32'd0;

        if ((state_q == S_RD) || (state_q == S_CAP) || (state_q == S_WR)) begin
            mem_addr_o = {addr_q[31:2], 2'b00};
        end
        if (state_q == S_WR) begin
            mem_wdata_o = data_q;
        end

        // Response registers only change on entry to RESP so they hold between responses.
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    we_d     = req_we_i;
                    funct3_d = req_funct3_i;
                    addr_d   = req_addr_i;
                    data_d   = req_wdata_i;
                    if (req_err) begin
                        state_d = S_RESP;
                        rdata_d = 32'd0;
                        err_d   = 1'b1;
                    end else if (req_we_i && (req_funct3_i[1:0] == 2'b10)) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                state_d = S_CAP;
            end
            S_CAP: begin
                if (we_q) begin
                    data_d  = merge_word;
                    state_d = S_WR;
                end else begin
                    rdata_d = load_ext;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end
            end
            S_WR: begin
                rdata_d = 32'd0;
                err_d   = 1'b0;
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b0;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 32'd0;
            data_q   <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

MEM-stage load/store initiator that sits between the pipeline and `data_memory`, which is a word-only, single-port responder. It drives that memory's request side: word-aligned address, read enable, write enable and write data. It consumes the registered read data, which is valid one cycle after a read. It adds RV32I byte/halfword semantics: lane extraction with sign or zero extension for loads, and read-modify-write for sub-word stores. It also detects misaligned and illegal accesses.

## Interface
Parameters:
- none (data path fixed at 32 bits; single memory master)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  pipeline presents a request
- req_ready_o  out  1  unit accepts a request this cycle
- req_we_i  in  1  1 = store, 0 = load
- req_funct3_i  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data (low bits used for SB/SH)
- resp_valid_o  out  1  one-cycle completion pulse
- resp_rdata_o  out  32  extended load data (0 for stores and errors)
- resp_err_o  out  1  misaligned or illegal funct3
- mem_addr_o  out  32  word address {addr[31:2],2'b00}
- mem_wdata_o  out  32  write word
- mem_read_en_o  out  1  memory read strobe
- mem_write_en_o  out  1  memory write strobe
- mem_rdata_i  in  32  memory read data, valid the cycle after mem_read_en_o

## Operation
- States: IDLE, RD, CAP, WR, RESP. Reset state is IDLE.
- req_ready_o = 1 only in IDLE. An accept (valid&&ready) latches we, funct3, addr and wdata.
- Error check at accept:
  - halfword with addr[0]=1, or word with addr[1:0]≠0, is misaligned.
  - Illegal funct3: load 011/110/111, store ≥011.
  - On error: IDLE→RESP, no memory strobe ever, resp_err_o=1, resp_rdata_o=0.
- Load flow: IDLE→RD→CAP→RESP.
  - In CAP, mem_rdata_i is extracted into resp_rdata_o.
  - LB/LBU select byte lane addr[1:0]; LH/LHU select half lane addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- SW flow: IDLE→WR→RESP; mem_wdata_o = req_wdata.
- SB/SH flow: IDLE→RD→CAP→WR→RESP.
  - In CAP the merge word is registered: mem_rdata_i with the addressed lane replaced.
  - SB replaces byte lane addr[1:0] with wdata[7:0]; SH replaces half lane addr[1] with wdata[15:0].
- RESP: resp_valid_o=1 for exactly one cycle, then →IDLE.
- resp_rdata_o/resp_err_o are meaningful only while resp_valid_o=1; they hold their value otherwise.
- Memory outputs:
  - mem_read_en_o=1 only in RD; mem_write_en_o=1 only in WR.
  - mem_addr_o is the latched word address in RD/CAP/WR, otherwise 0.
  - mem_wdata_o is the data register in WR, otherwise 0.
- RMW atomicity comes from being the sole memory master; no other agent may write memory.

## Timing
- Accept at cycle T. resp_valid_o is asserted in:
  - error: T+1
  - SW: T+2 (write strobe at T+1)
  - loads: T+3 (read strobe T+1, capture T+2)
  - SB/SH: T+4 (read T+1, merge T+2, write T+3)
- Next accept is possible at the earliest the cycle after RESP. req_valid_i held high is ignored outside IDLE.
- Reset values: state IDLE, req_ready_o=1 after release; every other output 0; internal latches 0.
- Reset mid-operation aborts immediately.
  - No strobe is issued after rst_n deasserts.
  - A write strobe already sampled by memory stands; one not yet issued is discarded, so a partial RMW leaves memory unchanged.
  - No resp_valid_o for the aborted request.
- All outputs come from registers or are decoded from the state register; no combinational path from req_* to mem_*.

## Test plan
- SW 0x10 = 0xDEADBEEF at T:
  - mem_write_en_o high only at T+1, addr 0x10.
  - resp at T+2, err 0.
  - Then LW 0x10 → resp T+3, rdata 0xDEADBEEF.
- Memory word 0x10 = 0x11223344; SB 0x13 wdata 0x000000AA:
  - One read, then one write of 0xAA223344; resp at T+4.
  - LB 0x13 → 0xFFFFFFAA; LBU 0x13 → 0x000000AA.
- Memory word 0x10 = 0xDEADBEEF; SH 0x12 wdata 0x8001:
  - Memory becomes 0x8001BEEF.
  - LH 0x12 → 0xFFFF8001; LHU 0x12 → 0x00008001; LH 0x10 → 0xFFFFBEEF.
- Error cases each give resp at T+1 with err 1, rdata 0, and no mem_read_en_o/mem_write_en_o pulse; memory unchanged:
  - LW 0x06
  - SH 0x05
  - load funct3 011
- Reset pulse during CAP of SB 0x13 onto 0x11223344:
  - All outputs 0 during reset; no write strobe.
  - Word remains 0x11223344; req_ready_o=1 after release.
- req_valid_i held high with back-to-back LW requests:
  - req_ready_o low from T+1 to T+3.
  - Second request accepted at T+4; responses in order with correct data.
